// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC/accumulate stage of the matmul PE.
package mac_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } mac_state_e;

  // Cycles between accepting the final pair and its write landing in the tile.
  localparam int FLUSH_CYCLES = 2;

  // C tile address {j, i}; a_w is the width of the i field.
  function automatic logic [15:0] c_addr(input logic [7:0] i, input logic [7:0] j,
                                         input int unsigned a_w);
    return (16'(j) << a_w) | 16'(i);
  endfunction

endpackage

// File: rtl/acc_ram.sv
// Register-array C tile: one combinational read for accumulate, one write,
// and an independent combinational read used by the drain path.
module acc_ram #(
  parameter int D_WIDTH = 64,
  parameter int AW      = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [D_WIDTH-1:0] rdata,
  input  logic [AW-1:0]      daddr,
  output logic [D_WIDTH-1:0] ddata
);

  logic [D_WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
  assign ddata = mem[daddr];

endmodule

// File: rtl/mac_accum_c.sv
// Multiply-accumulate stage: accumulates A*B into a local C tile over K rounds,
// then streams the finished tile out through a valid/ready port.
module mac_accum_c
  import mac_pkg::*;
#(
  parameter int D_WIDTH      = 64,
  parameter int A_PART_WIDTH = 1,
  parameter int B_NUM_WIDTH  = 1,
  parameter int K_NUM_WIDTH  = 1,
  parameter int PID          = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [D_WIDTH-1:0]                data_A_in,
  input  logic [D_WIDTH-1:0]                data_B_in,
  input  logic                              valid_AB_in,
  output logic                              busy_out,
  output logic [D_WIDTH-1:0]                data_C_out,
  output logic [A_PART_WIDTH+B_NUM_WIDTH-1:0] addr_C_out,
  output logic [7:0]                        pid_out,
  output logic                              valid_C_out,
  input  logic                              ready_C_in,
  output logic                              tile_done_out,
  output logic                              overflow_err_out
);

  localparam int CW = A_PART_WIDTH + B_NUM_WIDTH;

  // Two-stage pipeline has no forwarding, so an address must not recur within 2 pairs.
  if (CW < 2) begin : g_hazard_chk
    $error("mac_accum_c: A_PART_WIDTH + B_NUM_WIDTH must be >= 2");
  end

  mac_state_e               state_reg;
  logic [A_PART_WIDTH-1:0]  i_reg;
  logic [B_NUM_WIDTH-1:0]   j_reg;
  logic [K_NUM_WIDTH-1:0]   k_reg;
  logic [1:0]               flush_cnt_reg;
  logic [CW-1:0]            drain_cnt_reg;

  logic                     s1_valid_reg;
  logic                     s1_first_reg;
  logic [D_WIDTH-1:0]       s1_prod_reg;
  logic [CW-1:0]            s1_addr_reg;

  logic [D_WIDTH-1:0]       data_c_reg;
  logic [CW-1:0]            addr_c_reg;
  logic                     valid_c_reg;
  logic                     tile_done_reg;
  logic                     overflow_reg;

  logic                     busy;
  logic                     accept;
  logic                     last_pair;
  logic [CW-1:0]            pair_addr;
  logic signed [D_WIDTH-1:0] prod;
  logic [D_WIDTH-1:0]       rd_data;
  logic [D_WIDTH-1:0]       wr_data;
  logic [D_WIDTH-1:0]       dr_data;

  assign busy      = (state_reg != ACCUM);
  assign accept    = valid_AB_in && !busy;
  assign last_pair = (&i_reg) && (&j_reg) && (&k_reg);
  assign pair_addr = CW'(c_addr(8'(i_reg), 8'(j_reg), A_PART_WIDTH));
  assign prod      = $signed(data_A_in) * $signed(data_B_in);

  // The first round overwrites, which clears the previous tile without a reset pass.
  assign wr_data = s1_first_reg ? s1_prod_reg : rd_data + s1_prod_reg;

  acc_ram #(
    .D_WIDTH (D_WIDTH),
    .AW      (CW)
  ) u_acc_ram (
    .clk   (clk),
    .we    (s1_valid_reg),
    .waddr (s1_addr_reg),
    .wdata (wr_data),
    .raddr (s1_addr_reg),
    .rdata (rd_data),
    .daddr (drain_cnt_reg),
    .ddata (dr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACCUM;
      i_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      flush_cnt_reg <= '0;
      drain_cnt_reg <= '0;
      s1_valid_reg  <= 1'b0;
      s1_first_reg  <= 1'b0;
      s1_prod_reg   <= '0;
      s1_addr_reg   <= '0;
      data_c_reg    <= '0;
      addr_c_reg    <= '0;
      valid_c_reg   <= 1'b0;
      tile_done_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      tile_done_reg <= 1'b0;
      s1_valid_reg  <= accept;
      if (valid_AB_in && busy) overflow_reg <= 1'b1;

      if (accept) begin
        s1_prod_reg  <= prod;
        s1_addr_reg  <= pair_addr;
        s1_first_reg <= (k_reg == '0);
        i_reg        <= i_reg + 1'b1;
        if (&i_reg) begin
          j_reg <= j_reg + 1'b1;
          if (&j_reg) k_reg <= k_reg + 1'b1;
        end
      end

      case (state_reg)
        ACCUM: begin
          flush_cnt_reg <= '0;
          if (accept && last_pair) state_reg <= FLUSH;
        end
        FLUSH: begin
          if (flush_cnt_reg == 2'(FLUSH_CYCLES - 1)) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= '0;
            valid_c_reg   <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
          end
        end
        DRAIN: begin
          // drain_cnt_reg always points at the next entry to present.
          if (!valid_c_reg) begin
            data_c_reg    <= dr_data;
            addr_c_reg    <= drain_cnt_reg;
            valid_c_reg   <= 1'b1;
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end else if (ready_C_in) begin
            if (&addr_c_reg) begin
              valid_c_reg   <= 1'b0;
              tile_done_reg <= 1'b1;
              state_reg     <= ACCUM;
              i_reg         <= '0;
              j_reg         <= '0;
              k_reg         <= '0;
            end else begin
              data_c_reg    <= dr_data;
              addr_c_reg    <= drain_cnt_reg;
              drain_cnt_reg <= drain_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  assign busy_out         = busy;
  assign data_C_out       = data_c_reg;
  assign addr_C_out       = addr_c_reg;
  assign valid_C_out      = valid_c_reg;
  assign tile_done_out    = tile_done_reg;
  assign overflow_err_out = overflow_reg;
  assign pid_out          = 8'(PID);

endmodule

// File: tb/tb_mac_accum_c.sv
// Directed bench for mac_accum_c with 2x2 C tile and two accumulation rounds.
module tb_mac_accum_c;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data_A_in;
  logic [63:0] data_B_in;
  logic        valid_AB_in;
  logic        busy_out;
  logic [63:0] data_C_out;
  logic [1:0]  addr_C_out;
  logic [7:0]  pid_out;
  logic        valid_C_out;
  logic        ready_C_in;
  logic        tile_done_out;
  logic        overflow_err_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] la [8];
  logic [63:0] lb [8];
  logic [63:0] ev [4];

  always #5 clk = ~clk;

  mac_accum_c #(
    .D_WIDTH      (64),
    .A_PART_WIDTH (1),
    .B_NUM_WIDTH  (1),
    .K_NUM_WIDTH  (1),
    .PID          (0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_A_in        (data_A_in),
    .data_B_in        (data_B_in),
    .valid_AB_in      (valid_AB_in),
    .busy_out         (busy_out),
    .data_C_out       (data_C_out),
    .addr_C_out       (addr_C_out),
    .pid_out          (pid_out),
    .valid_C_out      (valid_C_out),
    .ready_C_in       (ready_C_in),
    .tile_done_out    (tile_done_out),
    .overflow_err_out (overflow_err_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_const(input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
    for (int p = 0; p < 8; p++) begin
      la[p] = a;
      lb[p] = b;
    end
    for (int m = 0; m < 4; m++) ev[m] = e;
  endtask

  task automatic feed(input bit gaps);
    for (int p = 0; p < 8; p++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 3));
        valid_AB_in = 1'b0;
        repeat (g) tick();
      end
      valid_AB_in = 1'b1;
      data_A_in   = la[p];
      data_B_in   = lb[p];
      tick();
    end
    valid_AB_in = 1'b0;
  endtask

  // Called one cycle after the final pair was accepted.
  task automatic drain(input string name, input bit bp, input bit poke);
    int          n = 0;
    int          cyc = 0;
    int          first_cyc = -1;
    bit          held = 1'b0;
    logic [63:0] hd;
    logic [1:0]  ha;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    chk({name, ".busy_after_last"}, 64'(busy_out), 64'd1);
    while (n < 4 && cyc < 200) begin
      ready_C_in = bp ? pat[cyc % 4] : 1'b1;
      if (poke) begin
        valid_AB_in = 1'b1;
        data_A_in   = 64'hdead;
        data_B_in   = 64'hbeef;
      end
      if (valid_C_out) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          chk({name, ".drain_latency"}, 64'(first_cyc), 64'd3);
        end
        if (held) begin
          chk({name, ".stall_data"}, data_C_out, hd);
          chk({name, ".stall_addr"}, 64'(addr_C_out), 64'(ha));
        end
        if (ready_C_in) begin
          chk({name, ".addr"}, 64'(addr_C_out), 64'(n));
          chk({name, ".data"}, data_C_out, ev[n]);
          $display("%s transfer %0d addr=%0d data=%0d", name, n, addr_C_out, $signed(data_C_out));
          n++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = data_C_out;
          ha   = addr_C_out;
        end
      end
      tick();
      cyc++;
    end
    valid_AB_in = 1'b0;
    chk({name, ".transfers"}, 64'(n), 64'd4);
    chk({name, ".tile_done"}, 64'(tile_done_out), 64'd1);
    chk({name, ".valid_dropped"}, 64'(valid_C_out), 64'd0);
    chk({name, ".busy_dropped"}, 64'(busy_out), 64'd0);
    tick();
    chk({name, ".tile_done_pulse"}, 64'(tile_done_out), 64'd0);
  endtask

  initial begin
    rst_n       = 1'b1;
    data_A_in   = '0;
    data_B_in   = '0;
    valid_AB_in = 1'b0;
    ready_C_in  = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("reset.busy",      64'(busy_out),         64'd0);
    chk("reset.valid_c",   64'(valid_C_out),      64'd0);
    chk("reset.tile_done", 64'(tile_done_out),    64'd0);
    chk("reset.overflow",  64'(overflow_err_out), 64'd0);
    chk("reset.data_c",    data_C_out,            64'd0);
    chk("reset.addr_c",    64'(addr_C_out),       64'd0);
    chk("reset.pid",       64'(pid_out),          64'd0);
    #3 rst_n = 1'b1;
    tick();

    // 1*1 over two rounds
    set_const(64'd1, 64'd1, 64'd2);
    feed(1'b0);
    drain("ones", 1'b0, 1'b0);

    // -3*5 over two rounds
    set_const(-64'sd3, 64'd5, -64'sd30);
    feed(1'b0);
    drain("signed", 1'b0, 1'b0);

    // 2^62*4 wraps to zero in each product
    set_const(64'h4000_0000_0000_0000, 64'd4, 64'd0);
    feed(1'b0);
    drain("wrap", 1'b0, 1'b0);

    // back-to-back tile with stalled drain: only this tile's sums may appear
    set_const(64'd7, -64'sd2, -64'sd28);
    feed(1'b0);
    drain("backpressure", 1'b1, 1'b0);

    // distinct operands per pair with random input gaps
    la = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8};
    lb = '{64'd10, 64'd7, 64'd4, 64'd1, -64'sd2, -64'sd5, -64'sd8, -64'sd11};
    ev = '{64'd0, -64'sd16, -64'sd44, -64'sd84};
    feed(1'b1);
    drain("bubbles", 1'b0, 1'b0);

    // pairs arriving while busy are dropped and flagged
    set_const(64'd3, 64'd3, 64'd18);
    chk("overflow.before", 64'(overflow_err_out), 64'd0);
    feed(1'b0);
    drain("overflow", 1'b0, 1'b1);
    chk("overflow.after", 64'(overflow_err_out), 64'd1);

    // reset in the middle of a drain
    set_const(64'd9, 64'd9, 64'd162);
    feed(1'b0);
    ready_C_in = 1'b1;
    for (int c = 0; c < 10 && !valid_C_out; c++) tick();
    chk("midreset.valid_before", 64'(valid_C_out), 64'd1);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("midreset.busy",      64'(busy_out),         64'd0);
    chk("midreset.valid_c",   64'(valid_C_out),      64'd0);
    chk("midreset.tile_done", 64'(tile_done_out),    64'd0);
    chk("midreset.overflow",  64'(overflow_err_out), 64'd0);
    chk("midreset.data_c",    data_C_out,            64'd0);
    chk("midreset.addr_c",    64'(addr_C_out),       64'd0);
    #1 rst_n = 1'b1;
    tick();

    set_const(64'd1, 64'd2, 64'd4);
    feed(1'b0);
    drain("after_reset", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
